// File: rtl/fsm_capture_pkg.sv
// rtl/fsm_capture_pkg.sv - shared types and helpers for the FSM output capture monitor
package fsm_capture_pkg;

  // Monitor control states; the encoding width is fixed at 8 bits.
  typedef enum logic [7:0] {
    S_INIT = 8'd0,
    S_RUN  = 8'd1,
    S_OVF  = 8'd2
  } state_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Drop counter increment that sticks at DROP_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? DROP_MAX : v + 8'd1;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - registered DEPTH-entry FIFO holding {word,stamp} records
module capture_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  // An empty FIFO presents zeros so the head never shows stale or uninitialised storage.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while not covered by level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fsm_output_capture.sv
// rtl/fsm_output_capture.sv - change monitor that stamps and queues every new output word
module fsm_output_capture #(
  parameter int DATA_W  = 32,
  parameter int STAMP_W = 16,
  parameter int DEPTH   = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_word,
  input  logic               enable,
  input  logic               clear_ovf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_word,
  output logic [STAMP_W-1:0] out_stamp,
  output logic               ovf,
  output logic [7:0]         drop_cnt,
  output logic [LW-1:0]      level
);
  import fsm_capture_pkg::*;

  state_e             state_q, state_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [DATA_W-1:0]  last_word_q, last_word_d;
  logic               cap_valid_q, cap_valid_d;
  logic [DATA_W-1:0]  cap_word_q, cap_word_d;
  logic [STAMP_W-1:0] cap_stamp_q, cap_stamp_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop;

  capture_fifo #(
    .WIDTH (DATA_W + STAMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({cap_word_q, cap_stamp_q}),
    .pop       (pop),
    .head_data ({out_word, out_stamp}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

  // Change detection is registered one stage; the stage below decides push versus drop.
  always_comb begin
    stamp_d     = stamp_q + STAMP_W'(1);
    last_word_d = in_word;
    cap_valid_d = (state_q != S_INIT) && enable && (in_word != last_word_q);
    cap_word_d  = in_word;
    cap_stamp_d = stamp_q;
    drop        = cap_valid_q && fifo_full && !pop;
    push        = cap_valid_q && !drop;
  end

  // Stamp counter, baseline tracker and the captured-change stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stamp_q     <= '0;
      last_word_q <= '0;
      cap_valid_q <= 1'b0;
      cap_word_q  <= '0;
      cap_stamp_q <= '0;
    end else begin
      stamp_q     <= stamp_d;
      last_word_q <= last_word_d;
      cap_valid_q <= cap_valid_d;
      cap_word_q  <= cap_word_d;
      cap_stamp_q <= cap_stamp_d;
    end
  end

  // Next-state, drop counting and overflow flag; a drop coinciding with clear restarts at 1.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (drop) begin
          state_d    = S_OVF;
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end
      S_OVF: begin
        if (clear_ovf) begin
          state_d    = drop ? S_OVF : S_RUN;
          drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end
      default: state_d = S_INIT;
    endcase
    ovf_d = (state_d == S_OVF);
  end

  // FSM state register with its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      drop_cnt_q <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fsm_output_capture.sv
// tb/tb_fsm_output_capture.sv - table, directed and randomized checks of fsm_output_capture
module tb_fsm_output_capture;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_word = '0;
  logic        enable = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [15:0] out_stamp;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_output_capture #(.DATA_W(32), .STAMP_W(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_word   (in_word),
    .enable    (enable),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_stamp (out_stamp),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, queue of {word,stamp}, one pending change record.
  int          m_cyc;
  logic [31:0] m_last;
  logic [47:0] mq[$];
  bit          m_pend_v;
  logic [47:0] m_pend;
  bit          m_ovf;
  int          m_drops;

  typedef struct {
    logic [31:0] in_word;
    bit          en;
    bit          rdy;
    bit          clr;
    bit          v;
    logic [31:0] w;
    logic [15:0] s;
    logic [2:0]  lvl;
    bit          o;
    logic [7:0]  d;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_last = '0; mq.delete(); m_pend_v = 0; m_pend = '0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_step();
    bit popped, dropped;
    popped  = (mq.size() != 0) && out_ready;
    dropped = m_pend_v && (mq.size() == DEPTH) && !popped;
    if (popped) void'(mq.pop_front());
    if (m_pend_v && !dropped) mq.push_back(m_pend);
    if (m_ovf && clear_ovf) begin
      m_ovf   = dropped;
      m_drops = dropped ? 1 : 0;
    end else if (dropped) begin
      m_ovf   = 1;
      m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
    end
    m_pend_v = (m_cyc != 0) && enable && (in_word != m_last);
    m_pend   = {in_word, 16'(m_cyc)};
    m_last   = in_word;
    m_cyc++;
  endtask

  task automatic model_check();
    logic [47:0] head;
    head = (mq.size() != 0) ? mq[0] : 48'd0;
    chk("m_valid", out_valid, mq.size() != 0);
    chk("m_word",  out_word,  head[47:16]);
    chk("m_stamp", out_stamp, head[15:0]);
    chk("m_level", level,     mq.size());
    chk("m_ovf",   ovf,       m_ovf);
    chk("m_drop",  drop_cnt,  m_drops);
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input logic [31:0] w, input bit en, input bit rdy, input bit clr);
    in_word = w; enable = en; out_ready = rdy; clear_ovf = clr;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_word",  out_word,  32'd0);
    chk("rst_stamp", out_stamp, 16'd0);
    chk("rst_level", level,     3'd0);
    chk("rst_ovf",   ovf,       1'b0);
    chk("rst_drop",  drop_cnt,  8'd0);
    reset = 1'b1;

    // Baseline cycles so the first table change lands at stamp 10.
    drive(32'd0, 1, 1, 0);
    repeat (10) tick();

    vecs.push_back('{32'd5,  1, 1, 0, 1'b0, 32'd0,  16'd0,  3'd0, 1'b0, 8'd0});
    vecs.push_back('{32'd5,  1, 1, 0, 1'b1, 32'd5,  16'd10, 3'd1, 1'b0, 8'd0});
    vecs.push_back('{32'd5,  1, 1, 0, 1'b0, 32'd0,  16'd0,  3'd0, 1'b0, 8'd0});
    vecs.push_back('{32'd6,  1, 0, 0, 1'b0, 32'd0,  16'd0,  3'd0, 1'b0, 8'd0});
    vecs.push_back('{32'd7,  1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd1, 1'b0, 8'd0});
    vecs.push_back('{32'd8,  1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd2, 1'b0, 8'd0});
    vecs.push_back('{32'd9,  1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd3, 1'b0, 8'd0});
    vecs.push_back('{32'd10, 1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd10, 1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd4, 1'b1, 8'd1});
    vecs.push_back('{32'd10, 1, 0, 1, 1'b1, 32'd6,  16'd13, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd11, 1, 0, 0, 1'b1, 32'd6,  16'd13, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd11, 1, 1, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd11, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd12, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b0, 8'd0});
    vecs.push_back('{32'd13, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b1, 8'd1});
    vecs.push_back('{32'd13, 1, 0, 1, 1'b1, 32'd7,  16'd14, 3'd4, 1'b1, 8'd1});
    vecs.push_back('{32'd13, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b1, 8'd1});
    vecs.push_back('{32'd14, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b1, 8'd1});
    vecs.push_back('{32'd14, 1, 0, 0, 1'b1, 32'd7,  16'd14, 3'd4, 1'b1, 8'd2});
    vecs.push_back('{32'd14, 1, 0, 1, 1'b1, 32'd7,  16'd14, 3'd4, 1'b0, 8'd0});

    foreach (vecs[i]) begin
      drive(vecs[i].in_word, vecs[i].en, vecs[i].rdy, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].v);
      chk($sformatf("vec%0d_word", i),  out_word,  vecs[i].w);
      chk($sformatf("vec%0d_stamp", i), out_stamp, vecs[i].s);
      chk($sformatf("vec%0d_level", i), level,     vecs[i].lvl);
      chk($sformatf("vec%0d_ovf", i),   ovf,       vecs[i].o);
      chk($sformatf("vec%0d_drop", i),  drop_cnt,  vecs[i].d);
    end

    // Drop counter saturation with the FIFO held full.
    for (int i = 0; i < 300; i++) begin
      drive(32'd100 + 32'(i % 2), 1, 0, 0);
      tick();
    end
    chk("sat_drop", drop_cnt, 8'd255);
    chk("sat_ovf",  ovf,      1'b1);
    drive(32'd101, 1, 1, 1);
    tick();
    drive(32'd101, 1, 1, 0);
    repeat (6) tick();
    chk("drain_level", level, 3'd0);
    chk("clear_drop",  drop_cnt, 8'd0);

    // Disabled changes leave the FIFO empty; the baseline still follows in_word.
    for (int i = 1; i <= 3; i++) begin
      drive(32'(i), 0, 1, 0);
      tick();
    end
    drive(32'd3, 1, 1, 0);
    repeat (3) tick();
    chk("dis_valid", out_valid, 1'b0);
    chk("dis_drop",  drop_cnt,  8'd0);
    drive(32'd4, 1, 0, 0);
    repeat (2) tick();
    chk("en_valid", out_valid, 1'b1);
    chk("en_word",  out_word,  32'd4);
    drive(32'd4, 1, 1, 0);
    tick();

    // Asynchronous reset mid-drain with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(32'd20 + 32'(i), 1, 0, 0);
      tick();
    end
    drive(32'd22, 1, 0, 0);
    tick();
    chk("pre_rst_level", level, 3'd3);
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_level", level,     3'd0);
    chk("arst_word",  out_word,  32'd0);
    model_reset();
    tick();
    reset = 1'b1;
    drive(32'd22, 1, 1, 0);
    repeat (4) tick();
    chk("post_rst_valid", out_valid, 1'b0);
    drive(32'd23, 1, 0, 0);
    repeat (2) tick();
    chk("post_rst_word",  out_word,  32'd23);
    chk("post_rst_stamp", out_stamp, 16'd4);

    // Randomized traffic against the reference model, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      drive(w, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
